aes_decrypt_top: RTL and testbench
==================================

// Module: aes_decrypt_top
// PURPOSE
//   Iterative AES-128 inverse cipher (FIPS-197 InvCipher), one round per clock. Companion to the
//   AES_top encryptor: takes AES_top ciphertext plus the same cipher key, returns the plaintext.
//   Derives the round-10 key on the fly (forward expansion), then walks the schedule backwards
//   during the decrypt rounds. No round-key RAM.
//   Uses forward S-box (4x, key path) and inverse S-box (16x, data path) as combinational leaf instances.
// PARAMETERS
//   DATA_W   128  block/key width; only 128 is supported
//   NR       10   number of rounds; only 10 (AES-128) is supported
// PORTS
//   AES_clk             in   1    system clock, rising edge
//   AES_rst             in   1    asynchronous, active-high reset
//   AES_en              in   1    start request, sampled on rising edge in IDLE only
//   AES_data_in         in   128  ciphertext, byte 0 = [127:120], column-major per FIPS-197
//   AES_key_in          in   128  cipher key (same key given to AES_top)
//   AES_busy            out  1    high from capture edge until the edge that asserts valid
//   AES_data_out        out  128  plaintext, held until the next result
//   AES_data_out_valid  out  1    single-cycle pulse, coincident with new AES_data_out
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, all internal regs 0, AES_data_out=0, valid=0, busy=0.
//   FSM states: IDLE -> KEYEXP -> ROUND -> IDLE.
//   IDLE: on edge E with AES_en=1, capture data_reg<=AES_data_in, key_reg<=AES_key_in.
//     Set rcon<=8'h01, cnt<=1, busy<=1, state<=KEYEXP.
//   KEYEXP (edges E+1..E+10): key_reg<=next_fwd_key(key_reg,rcon); rcon<=xtime(rcon).
//     Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
//     At edge E+10 (cnt==10): key_reg=rk10; state_reg<=data_reg ^ rk10 (initial AddRoundKey).
//     Also rcon<=8'h36 and cnt<=9; state<=ROUND.
//   ROUND (edges E+11..E+20), round r=cnt from 9 down to 0, one round per edge:
//     key_reg<=prev_key(key_reg,rcon), giving rk[r]:
//       w[i-4]=w[i]^w[i-1] for i mod 4 != 0;
//       w[i-4]=w[i]^SubWord(RotWord(w[i-1]))^Rcon for i mod 4 == 0.
//     rcon<=inv_xtime(rcon), i.e. 36->1b->80->40->...->01.
//     t = InvSubBytes(InvShiftRows(state_reg)) ^ rk[r].
//     r>0: state_reg<=InvMixColumns(t).  r==0: AES_data_out<=t, valid<=1, busy<=0, state<=IDLE.
//   Latency: result visible 20 edges after capture edge; next start accepted on the edge after valid.
//     Max throughput one block per 21 cycles.
//   AES_en while busy: ignored, no queuing. AES_en held high continuously: restarts on the cycle valid pulses.
//     Inputs are re-sampled then, i.e. a back-to-back start.
//   AES_data_in/AES_key_in changes after capture: no effect on the running block.
//   valid is high exactly one cycle; AES_data_out unchanged when valid=0.
//   GF arithmetic: xtime(b)=(b<<1)^(b[7]?8'h1b:0); InvMixColumns uses {0e,0b,0d,09} matrix.
//   Reset asserted mid-operation: immediate abort to IDLE; outputs forced to reset values.
//     No valid is produced for the aborted block.
// TESTING
//   T1 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//      -> out 00112233445566778899aabbccddeeff, valid 20 edges after capture.
//   T2 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32.
//      -> out 3243f6a8885a308d313198a2e0370734.
//   T3 Round trip: feed AES_top output for key aa2bdb40bff6a5e8caa9ba3ebc1e2acc and
//      pt 00000021000000000000000000000000 -> recovers that pt exactly.
//   T4 Busy/ignore: pulse AES_en again at capture+5 with other data -> single valid, T1 result only.
//      Inputs changed mid-run -> result unchanged.
//   T5 Back-to-back: AES_en held high with T1 then T2 vectors -> two valid pulses 21 cycles apart.
//      Both results are correct.
//   T6 Reset mid-op: assert AES_rst at capture+7 for 1 cycle -> out=0, valid=0, busy=0, no pulse.
//      A fresh T1 run afterwards passes.

Source files
------------

// File: rtl/aes_decrypt_top.sv
// AES-128 inverse cipher, iterative, one round per clock; round keys derived on the fly, no key RAM.
// Latency: result and valid pulse 20 edges after the capture edge; next start accepted on the edge after valid.
// No backpressure: AES_en is ignored while busy (no queuing); the result is held until the next one.

// Forward S-box lookup (key-schedule path).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // Entry a sits at bit 8*(255-a)+7 downwards.
  assign y = TBL[{~a, 3'b111} -: 8];
endmodule

// Inverse S-box lookup (data path).
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  assign y = TBL[{~a, 3'b111} -: 8];
endmodule

module aes_decrypt_top #(
  parameter int DATA_W = 128,
  parameter int NR     = 10
) (
  input  logic              AES_clk,
  input  logic              AES_rst,
  input  logic              AES_en,
  input  logic [DATA_W-1:0] AES_data_in,
  input  logic [DATA_W-1:0] AES_key_in,
  output logic              AES_busy,
  output logic [DATA_W-1:0] AES_data_out,
  output logic              AES_data_out_valid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] KEYEXP = 2'd1;
  localparam logic [1:0] ROUND  = 2'd2;

  localparam logic [3:0] LAST_KEY = 4'(NR);

  logic [1:0]   fsm;
  logic [3:0]   cnt;
  logic [7:0]   rcon;
  logic [127:0] data_reg;
  logic [127:0] key_reg;
  logic [127:0] state_reg;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sbox_in, sbox_out;
  logic [127:0] fwd_key, prev_key;
  logic [127:0] isb, t, imc;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse of xtime: walks the Rcon sequence backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    logic [7:0] v;
    v = b[0] ? (b ^ 8'h1b) : b;
    return {b[0], v[7:1]};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // The four forward S-boxes are shared: forward expansion substitutes RotWord(w3),
  // the backward walk substitutes RotWord(w3^w2), which is w3 of the previous round key.
  always_comb begin
    w0 = key_reg[127:96];
    w1 = key_reg[95:64];
    w2 = key_reg[63:32];
    w3 = key_reg[31:0];
    sbox_in = (fsm == ROUND) ? {w3[23:0] ^ w2[23:0], w3[31:24] ^ w2[31:24]}
                             : {w3[23:0], w3[31:24]};
  end

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (.a(sbox_in[31-8*j -: 8]), .y(sbox_out[31-8*j -: 8]));
  end

  // Next and previous round keys from the current one.
  always_comb begin
    fwd_key[127:96]  = w0 ^ sbox_out ^ {rcon, 24'h0};
    fwd_key[95:64]   = w1 ^ fwd_key[127:96];
    fwd_key[63:32]   = w2 ^ fwd_key[95:64];
    fwd_key[31:0]    = w3 ^ fwd_key[63:32];
    prev_key[127:96] = w0 ^ sbox_out ^ {rcon, 24'h0};
    prev_key[95:64]  = w1 ^ w0;
    prev_key[63:32]  = w2 ^ w1;
    prev_key[31:0]   = w3 ^ w2;
  end

  // InvShiftRows is pure wiring: output byte (row,col) reads input byte (row,(col-row) mod 4).
  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    localparam int ROW = i % 4;
    localparam int SRC = ROW + 4 * (((i / 4) + 4 - ROW) % 4);
    aes_inv_sbox u_inv_sbox (.a(state_reg[127-8*SRC -: 8]), .y(isb[127-8*i -: 8]));
  end

  // AddRoundKey with the previous round key, then InvMixColumns per column.
  always_comb begin
    t = isb ^ prev_key;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
    end
  end

  // Control FSM, key register walk and data rounds.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      fsm                <= IDLE;
      cnt                <= 4'd0;
      rcon               <= 8'h00;
      data_reg           <= '0;
      key_reg            <= '0;
      state_reg          <= '0;
      AES_busy           <= 1'b0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
    end else begin
      AES_data_out_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (AES_en) begin
            data_reg <= AES_data_in;
            key_reg  <= AES_key_in;
            rcon     <= 8'h01;
            cnt      <= 4'd1;
            AES_busy <= 1'b1;
            fsm      <= KEYEXP;
          end
        end
        KEYEXP: begin
          key_reg <= fwd_key;
          if (cnt == LAST_KEY) begin
            // fwd_key is the last round key here; apply it as the initial AddRoundKey.
            state_reg <= data_reg ^ fwd_key;
            rcon      <= 8'h36;
            cnt       <= LAST_KEY - 4'd1;
            fsm       <= ROUND;
          end else begin
            rcon <= xtime(rcon);
            cnt  <= cnt + 4'd1;
          end
        end
        ROUND: begin
          key_reg <= prev_key;
          rcon    <= inv_xtime(rcon);
          if (cnt == 4'd0) begin
            AES_data_out       <= t;
            AES_data_out_valid <= 1'b1;
            AES_busy           <= 1'b0;
            fsm                <= IDLE;
          end else begin
            state_reg <= imc;
            cnt       <= cnt - 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Bench for aes_decrypt_top: FIPS-197 vectors, round trip through a behavioural encryptor,
// busy/ignore, back-to-back and mid-run reset, with a queue-based scoreboard.
module tb_aes_decrypt_top;

  logic         AES_clk;
  logic         AES_rst;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic         AES_busy;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;

  aes_decrypt_top #(.DATA_W(128), .NR(10)) dut (
    .AES_clk           (AES_clk),
    .AES_rst           (AES_rst),
    .AES_en            (AES_en),
    .AES_data_in       (AES_data_in),
    .AES_key_in        (AES_key_in),
    .AES_busy          (AES_busy),
    .AES_data_out      (AES_data_out),
    .AES_data_out_valid(AES_data_out_valid)
  );

  typedef struct packed {
    logic [127:0] dat;
    logic [31:0]  cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           n_valid = 0;
  logic [31:0]  cyc = 0;
  logic [127:0] last_out = '0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K3 = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
  localparam logic [127:0] P3 = 128'h00000021000000000000000000000000;

  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  always @(posedge AES_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural encryptor (GF arithmetic, no tables) ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv = 8'h00, r1, r2, r3, r4;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, x);
    end
    r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
    return inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_f(tmp[23:16]), sbox_f(tmp[15:8]), sbox_f(tmp[7:0]), sbox_f(tmp[31:24])} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_f(s[(i%4) + 4*(((i/4) + (i%4)) % 4)]);
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge AES_clk) begin
    exp_t e;
    if (AES_rst) begin
      last_out = '0;
    end else if (AES_data_out_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got out %h at cycle %0d, no result expected", AES_data_out, cyc);
      end else begin
        e = sb_q.pop_front();
        check("result", AES_data_out, e.dat);
        check("latency_cycle", 128'(cyc), 128'(e.cyc));
        check("busy_at_valid", 128'(AES_busy), 128'd0);
      end
      last_out = AES_data_out;
    end else if (AES_data_out !== last_out) begin
      check("out_held", AES_data_out, last_out);
      last_out = AES_data_out;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_block(input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] exp_pt, input bit push);
    @(posedge AES_clk); #1;
    AES_en = 1'b1; AES_data_in = ct; AES_key_in = key;
    @(posedge AES_clk); #1;
    if (push) sb_q.push_back('{dat: exp_pt, cyc: cyc + 32'd20});
    AES_en = 1'b0;
    check("busy_after_capture", 128'(AES_busy), 128'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge AES_clk);
      n++;
    end
    @(negedge AES_clk); #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending after %0d cycles", sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  initial begin
    int v0, cap;
    logic [127:0] c3;
    AES_rst = 1'b1; AES_en = 1'b0; AES_data_in = '0; AES_key_in = '0;
    repeat (3) @(posedge AES_clk);
    #1;
    check("reset_out", AES_data_out, 128'd0);
    check("reset_valid", 128'(AES_data_out_valid), 128'd0);
    check("reset_busy", 128'(AES_busy), 128'd0);
    AES_rst = 1'b0;

    // T1, T2
    start_block(C1, K1, P1, 1'b1); drain(60);
    start_block(C2, K2, P2, 1'b1); drain(60);

    // T3 round trip
    c3 = aes_enc(P3, K3);
    start_block(c3, K3, P3, 1'b1); drain(60);

    // T4 start request and input changes while busy
    v0 = n_valid;
    start_block(C1, K1, P1, 1'b1);
    repeat (4) @(posedge AES_clk);
    #1; AES_en = 1'b1; AES_data_in = C2; AES_key_in = K2;
    @(posedge AES_clk);
    #1; AES_en = 1'b0; AES_data_in = 128'hdeadbeef_0badf00d_12345678_9abcdef0; AES_key_in = ~K1;
    drain(60);
    repeat (25) @(posedge AES_clk);
    #1; check("t4_single_valid", 128'(n_valid - v0), 128'd1);

    // T5 back-to-back with AES_en held high
    v0 = n_valid;
    @(posedge AES_clk); #1;
    AES_en = 1'b1; AES_data_in = C1; AES_key_in = K1;
    @(posedge AES_clk); #1;
    cap = cyc;
    sb_q.push_back('{dat: P1, cyc: cap + 32'd20});
    sb_q.push_back('{dat: P2, cyc: cap + 32'd41});
    AES_data_in = C2; AES_key_in = K2;
    repeat (21) @(posedge AES_clk);
    #1; AES_en = 1'b0; AES_data_in = '0; AES_key_in = '0;
    check("t5_second_capture_busy", 128'(AES_busy), 128'd1);
    drain(60);
    #1; check("t5_two_valids", 128'(n_valid - v0), 128'd2);

    // T6 reset mid-operation
    v0 = n_valid;
    start_block(C1, K1, P1, 1'b0);
    repeat (6) @(posedge AES_clk);
    #1; AES_rst = 1'b1;
    #1;
    check("t6_rst_out", AES_data_out, 128'd0);
    check("t6_rst_valid", 128'(AES_data_out_valid), 128'd0);
    check("t6_rst_busy", 128'(AES_busy), 128'd0);
    @(posedge AES_clk); #1; AES_rst = 1'b0;
    repeat (30) @(posedge AES_clk);
    #1;
    check("t6_no_pulse", 128'(n_valid - v0), 128'd0);
    check("t6_idle_busy", 128'(AES_busy), 128'd0);
    start_block(C1, K1, P1, 1'b1); drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
